stream_bootloader: RTL and testbench

//  Parametrised bootloader/frame-dumper on a byte-stream link; UART sits outside on rx/tx byte handshakes.
//  RX side loads COUNT-prefixed records into triangle memory and holds the rest of the system in reset.
//  TX side streams fill_time, then every frame-buffer word, MSB byte first, with tx_ready backpressure.

---
 rtl/stream_bootloader.sv | 238 +++++++++++++++++++++++
 tb/tb_stream_bootloader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bootloader.sv
// Byte-stream bootloader (RX records into triangle memory) and frame dumper (TX fill_time + frame buffer).
// Optional per-record XOR checksum with resend on mismatch: define CHECKSUM_EN.
module stream_bootloader #(
  parameter int RECORD_BYTES = 18,
  parameter int COUNT_BYTES  = 4,
  parameter int ADDR_W       = 32,
  parameter int PIXEL_BYTES  = 3,
  parameter int TIME_BYTES   = 3,
  parameter int FB_WORDS     = 2073600,
  localparam int FB_AW       = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bootload_en,
  input  logic                      transmit_en,
  input  logic                      done_drawing,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic                      rec_valid,
  output logic [ADDR_W-1:0]         rec_addr,
  output logic [8*RECORD_BYTES-1:0] rec_data,
  output logic                      load_done,
  output logic                      system_rst_n,
  input  logic [8*TIME_BYTES-1:0]   fill_time,
  output logic                      fb_rd_en,
  output logic [FB_AW-1:0]          fb_addr,
  input  logic [8*PIXEL_BYTES-1:0]  fb_rd_data,
  output logic                      tx_valid,
  output logic [7:0]                tx_byte,
  input  logic                      tx_ready,
  output logic [15:0]               csum_err_cnt
);

  localparam int CW   = 8*COUNT_BYTES;
  localparam int RMAX = (RECORD_BYTES > COUNT_BYTES) ? RECORD_BYTES : COUNT_BYTES;
  localparam int RBW  = $clog2(RMAX + 1);
  localparam int TMAX = (TIME_BYTES > PIXEL_BYTES) ? TIME_BYTES : PIXEL_BYTES;
  localparam int TBW  = $clog2(TMAX + 1);
  localparam int SW   = 8*TMAX;
  localparam int TW   = 8*TIME_BYTES;
  localparam int PW   = 8*PIXEL_BYTES;

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {RX_IDLE, RX_COUNT, RX_DATA, RX_CSUM, RX_WRITE, RX_DONE} rx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_COUNT, RX_DATA, RX_WRITE, RX_DONE} rx_state_t;
`endif
  typedef enum logic [2:0] {TX_IDLE, TX_TIME, TX_FETCH, TX_LATCH, TX_PIXEL} tx_state_t;

  rx_state_t         rx_state;
  tx_state_t         tx_state;
  logic              bl_q;
  logic [CW-1:0]     cnt_sr;
  logic [ADDR_W-1:0] count_w;
  logic [ADDR_W-1:0] idx;
  logic [RBW-1:0]    rbcnt;
  logic [SW-1:0]     sh;
  logic [TBW-1:0]    tbcnt;

  assign system_rst_n = rst_n & ~bootload_en;
  assign count_w      = ADDR_W'(cnt_sr);
  assign rec_addr     = idx;
  assign tx_byte      = sh[SW-1 -: 8];

`ifdef CHECKSUM_EN
  logic [7:0]  csum;
  logic [15:0] err_q;
  assign csum_err_cnt = err_q;
`else
  assign csum_err_cnt = '0;
`endif

  // Both the count header and record bytes shift in from the top, so the first byte lands in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      bl_q      <= 1'b0;
      cnt_sr    <= '0;
      idx       <= '0;
      rbcnt     <= '0;
      rec_data  <= '0;
      rec_valid <= 1'b0;
      load_done <= 1'b0;
`ifdef CHECKSUM_EN
      csum      <= '0;
      err_q     <= '0;
`endif
    end else begin
      bl_q      <= bootload_en;
      rec_valid <= 1'b0;
      if (rx_state != RX_IDLE && rx_state != RX_DONE && !bootload_en) begin
        rx_state <= RX_IDLE;
      end else begin
        case (rx_state)
          RX_IDLE: if (bootload_en && !bl_q) begin
            rx_state  <= RX_COUNT;
            cnt_sr    <= '0;
            idx       <= '0;
            rbcnt     <= '0;
            load_done <= 1'b0;
          end
          RX_COUNT: if (rx_valid) begin
            cnt_sr <= {rx_byte, cnt_sr[CW-1:8]};
            if (rbcnt == RBW'(COUNT_BYTES-1)) begin
              rbcnt <= '0;
              if (ADDR_W'({rx_byte, cnt_sr[CW-1:8]}) == '0) begin
                rx_state  <= RX_DONE;
                load_done <= 1'b1;
              end else begin
                rx_state <= RX_DATA;
              end
            end else begin
              rbcnt <= rbcnt + RBW'(1);
            end
          end
          RX_DATA: if (rx_valid) begin
            rec_data <= {rx_byte, rec_data[8*RECORD_BYTES-1:8]};
`ifdef CHECKSUM_EN
            csum <= (rbcnt == '0) ? rx_byte : (csum ^ rx_byte);
`endif
            if (rbcnt == RBW'(RECORD_BYTES-1)) begin
              rbcnt <= '0;
`ifdef CHECKSUM_EN
              rx_state <= RX_CSUM;
`else
              rx_state  <= RX_WRITE;
              rec_valid <= 1'b1;
`endif
            end else begin
              rbcnt <= rbcnt + RBW'(1);
            end
          end
`ifdef CHECKSUM_EN
          RX_CSUM: if (rx_valid) begin
            if (rx_byte == csum) begin
              rx_state  <= RX_WRITE;
              rec_valid <= 1'b1;
            end else begin
              rx_state <= RX_DATA;
              if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            end
          end
`endif
          RX_WRITE: begin
            idx <= idx + ADDR_W'(1);
            if (idx + ADDR_W'(1) == count_w) begin
              rx_state  <= RX_DONE;
              load_done <= 1'b1;
            end else begin
              rx_state <= RX_DATA;
              // A byte arriving during the write strobe starts the next record.
              if (rx_valid) begin
                rec_data <= {rx_byte, rec_data[8*RECORD_BYTES-1:8]};
                rbcnt    <= RBW'(1);
`ifdef CHECKSUM_EN
                csum     <= rx_byte;
`endif
              end
            end
          end
          RX_DONE: if (!bootload_en) rx_state <= RX_IDLE;
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // Bootload holds the TX side in reset alongside the rest of the system.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
      tx_valid <= 1'b0;
      sh       <= '0;
      tbcnt    <= '0;
    end else if (bootload_en) begin
      tx_state <= TX_IDLE;
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
      tx_valid <= 1'b0;
      sh       <= '0;
      tbcnt    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (done_drawing && transmit_en) begin
          tx_state <= TX_TIME;
          sh       <= SW'(fill_time) << (SW - TW);
          tx_valid <= 1'b1;
          tbcnt    <= '0;
        end
        TX_TIME: if (tx_ready) begin
          sh <= sh << 8;
          if (tbcnt == TBW'(TIME_BYTES-1)) begin
            tx_valid <= 1'b0;
            tbcnt    <= '0;
            if (transmit_en) begin
              tx_state <= TX_FETCH;
              fb_rd_en <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tbcnt <= tbcnt + TBW'(1);
          end
        end
        TX_FETCH: begin
          fb_rd_en <= 1'b0;
          tx_state <= TX_LATCH;
        end
        TX_LATCH: begin
          sh       <= SW'(fb_rd_data) << (SW - PW);
          tx_valid <= 1'b1;
          tx_state <= TX_PIXEL;
        end
        TX_PIXEL: if (tx_ready) begin
          sh <= sh << 8;
          if (tbcnt == TBW'(PIXEL_BYTES-1)) begin
            tx_valid <= 1'b0;
            tbcnt    <= '0;
            if (fb_addr == FB_AW'(FB_WORDS-1) || !transmit_en) begin
              tx_state <= TX_IDLE;
              fb_addr  <= '0;
            end else begin
              fb_addr  <= fb_addr + FB_AW'(1);
              tx_state <= TX_FETCH;
              fb_rd_en <= 1'b1;
            end
          end else begin
            tbcnt <= tbcnt + TBW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_bootloader.sv
// Directed bench for stream_bootloader: record loading, abort/restart, optional checksum, frame dump.
module tb_stream_bootloader;
  localparam int RB  = 18;
  localparam int FBW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bootload_en = 1'b0;
  logic          transmit_en = 1'b0;
  logic          done_drawing = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rec_valid;
  logic [31:0]   rec_addr;
  logic [8*RB-1:0] rec_data;
  logic          load_done;
  logic          system_rst_n;
  logic [23:0]   fill_time = 24'h0;
  logic          fb_rd_en;
  logic [1:0]    fb_addr;
  logic [23:0]   fb_rd_data = 24'h0;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_ready = 1'b0;
  logic [15:0]   csum_err_cnt;

  stream_bootloader #(.RECORD_BYTES(RB), .FB_WORDS(FBW)) dut (
    .clk(clk), .rst_n(rst_n), .bootload_en(bootload_en), .transmit_en(transmit_en),
    .done_drawing(done_drawing), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rec_valid(rec_valid), .rec_addr(rec_addr), .rec_data(rec_data), .load_done(load_done),
    .system_rst_n(system_rst_n), .fill_time(fill_time), .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
    .fb_rd_data(fb_rd_data), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .csum_err_cnt(csum_err_cnt)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: pixel k holds 0x112233 + k, one-cycle read latency.
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= 24'h112233 + 24'(fb_addr);

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
  end

  logic [31:0] rq_addr[$];
  logic [7:0]  rq_lo[$];
  logic [7:0]  rq_hi[$];
  logic [7:0]  tx_q[$];
  int          hold_err = 0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  always @(negedge clk) begin
    if (rec_valid) begin
      rq_addr.push_back(rec_addr);
      rq_lo.push_back(rec_data[7:0]);
      rq_hi.push_back(rec_data[8*RB-1 -: 8]);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
    if (prev_stall && (!tx_valid || tx_byte != prev_byte)) hold_err++;
    if (tx_valid && !tx_ready) stall_cnt++;
    prev_stall = tx_valid && !tx_ready && rst_n;
    prev_byte  = tx_byte;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_count(input logic [31:0] c);
    for (int i = 0; i < 4; i++) send_byte(c[8*i +: 8]);
  endtask

  task automatic send_rec(input logic [7:0] base);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < RB; i++) begin
      send_byte(base + 8'(i));
      x = x ^ (base + 8'(i));
    end
`ifdef CHECKSUM_EN
    send_byte(x);
`endif
  endtask

`ifdef CHECKSUM_EN
  task automatic send_bad_rec(input logic [7:0] base);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < RB; i++) begin
      send_byte(base + 8'(i));
      x = x ^ (base + 8'(i));
    end
    send_byte(x ^ 8'hFF);
  endtask
`endif

  task automatic check_rec(input string tag, input int k, input logic [31:0] a,
                           input logic [7:0] lo, input logic [7:0] hi);
    if (rq_addr.size() > k) begin
      check_eq({tag, "_addr"}, 64'(rq_addr[k]), 64'(a));
      check_eq({tag, "_lo"}, 64'(rq_lo[k]), 64'(lo));
      check_eq({tag, "_hi"}, 64'(rq_hi[k]), 64'(hi));
    end
  endtask

  task automatic pulse_draw();
    done_drawing = 1'b1;
    tick(1);
    done_drawing = 1'b0;
  endtask

  logic [7:0] exp_tx [15] = '{8'h0A, 8'h0B, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h34,
                              8'h11, 8'h22, 8'h35, 8'h11, 8'h22, 8'h36};

  initial begin
    tick(3);
    check_eq("rst_rec_valid", 64'(rec_valid), 64'd0);
    check_eq("rst_load_done", 64'(load_done), 64'd0);
    check_eq("rst_sys_rst_n", 64'(system_rst_n), 64'd0);
    check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("rst_fb_rd_en", 64'(fb_rd_en), 64'd0);
    check_eq("rst_fb_addr", 64'(fb_addr), 64'd0);
    check_eq("rst_rec_addr", 64'(rec_addr), 64'd0);
    check_eq("rst_csum_err", 64'(csum_err_cnt), 64'd0);
    rst_n = 1'b1;
    tick(1);
    check_eq("run_sys_rst_n", 64'(system_rst_n), 64'd1);

    // Two records streamed back to back, second starts in the write cycle
    bootload_en = 1'b1;
    tick(2);
    check_eq("t1_sys_rst_n", 64'(system_rst_n), 64'd0);
    send_count(32'd2);
    send_rec(8'h00);
    send_rec(8'h12);
    tick(3);
    check_eq("t1_rec_count", 64'(rq_addr.size()), 64'd2);
    check_rec("t1_rec0", 0, 32'd0, 8'h00, 8'h11);
    check_rec("t1_rec1", 1, 32'd1, 8'h12, 8'h23);
    check_eq("t1_load_done", 64'(load_done), 64'd1);
    send_byte(8'hAA);
    tick(2);
    check_eq("t1_extra_ignored", 64'(rq_addr.size()), 64'd2);
    bootload_en = 1'b0;
    tick(2);
    check_eq("t1_load_done_held", 64'(load_done), 64'd1);
    check_eq("t1_sys_rst_rel", 64'(system_rst_n), 64'd1);

    // Zero-count header
    rq_addr.delete(); rq_lo.delete(); rq_hi.delete();
    bootload_en = 1'b1;
    tick(2);
    check_eq("t2_load_done_clr", 64'(load_done), 64'd0);
    send_count(32'd0);
    tick(3);
    check_eq("t2_load_done", 64'(load_done), 64'd1);
    check_eq("t2_no_rec", 64'(rq_addr.size()), 64'd0);
    check_eq("t2_sys_rst_n", 64'(system_rst_n), 64'd0);
    bootload_en = 1'b0;
    tick(2);

    // Abort mid record, then restart from index 0
    bootload_en = 1'b1;
    tick(2);
    send_count(32'd2);
    send_rec(8'h00);
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i));
    tick(2);
    bootload_en = 1'b0;
    tick(3);
    check_eq("t4_one_rec", 64'(rq_addr.size()), 64'd1);
    check_eq("t4_load_done", 64'(load_done), 64'd0);
    bootload_en = 1'b1;
    tick(2);
    send_count(32'd1);
    send_rec(8'h40);
    tick(3);
    check_eq("t4_rec_count", 64'(rq_addr.size()), 64'd2);
    check_rec("t4_restart", 1, 32'd0, 8'h40, 8'h51);
    check_eq("t4_load_done2", 64'(load_done), 64'd1);
    bootload_en = 1'b0;
    tick(2);

`ifdef CHECKSUM_EN
    rq_addr.delete(); rq_lo.delete(); rq_hi.delete();
    bootload_en = 1'b1;
    tick(2);
    send_count(32'd1);
    send_bad_rec(8'h50);
    tick(3);
    check_eq("t5_err_cnt", 64'(csum_err_cnt), 64'd1);
    check_eq("t5_no_rec", 64'(rq_addr.size()), 64'd0);
    check_eq("t5_not_done", 64'(load_done), 64'd0);
    send_rec(8'h50);
    tick(3);
    check_eq("t5_one_rec", 64'(rq_addr.size()), 64'd1);
    check_rec("t5_rec", 0, 32'd0, 8'h50, 8'h61);
    check_eq("t5_load_done", 64'(load_done), 64'd1);
    check_eq("t5_err_cnt2", 64'(csum_err_cnt), 64'd1);
    bootload_en = 1'b0;
    tick(2);
`endif

    // Full frame dump under random backpressure
    fill_time   = 24'h0A0B0C;
    transmit_en = 1'b1;
    rand_rdy    = 1'b1;
    pulse_draw();
    for (int c = 0; c < 500 && tx_q.size() < 15; c++) tick(1);
    tick(20);
    rand_rdy = 1'b0;
    tx_ready = 1'b1;
    check_eq("t3_byte_count", 64'(tx_q.size()), 64'd15);
    for (int i = 0; i < 15; i++)
      if (i < tx_q.size()) check_eq($sformatf("t3_byte%0d", i), 64'(tx_q[i]), 64'(exp_tx[i]));
    check_eq("t3_fb_addr_wrap", 64'(fb_addr), 64'd0);
    check_eq("t3_tx_idle", 64'(tx_valid), 64'd0);
    check_eq("t3_hold_err", 64'(hold_err), 64'd0);
    check_eq("t3_stalls_seen", 64'(stall_cnt != 0), 64'd1);

    // transmit_en dropped during pixel 1: that pixel completes, then idle
    tx_q.delete();
    tick(2);
    pulse_draw();
    for (int c = 0; c < 100 && !(tx_valid && fb_addr == 2'd1); c++) tick(1);
    transmit_en = 1'b0;
    tick(20);
    check_eq("te_byte_count", 64'(tx_q.size()), 64'd9);
    if (tx_q.size() >= 9) check_eq("te_last_byte", 64'(tx_q[8]), 64'h34);
    check_eq("te_fb_addr", 64'(fb_addr), 64'd0);
    check_eq("te_tx_idle", 64'(tx_valid), 64'd0);

    // Reset asserted mid pixel
    tx_q.delete();
    transmit_en = 1'b1;
    pulse_draw();
    for (int c = 0; c < 100 && !(tx_valid && fb_addr == 2'd2); c++) tick(1);
    check_eq("t6_mid_pixel", 64'(tx_valid && fb_addr == 2'd2), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("t6_fb_addr", 64'(fb_addr), 64'd0);
    check_eq("t6_fb_rd_en", 64'(fb_rd_en), 64'd0);
    check_eq("t6_sys_rst_n", 64'(system_rst_n), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check_eq("t6_stays_idle", 64'(tx_valid), 64'd0);
    check_eq("t6_fb_addr_idle", 64'(fb_addr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
